pulse_burst_gen: RTL and testbench
==================================

# pulse_burst_gen

Programmable pulse-burst generator: on a start command it drives a registered output with a burst of NUM pulses, each HIGH_W cycles high followed by LOW_W cycles low, then signals completion. It is the transmitting end for the team's two-flop synchronizer plus rising-edge detector. Every pulse it emits is followed by a guaranteed low gap, so a downstream edge detector sees exactly one rising edge per pulse. It sits in the CLK domain and is driven by control logic or a test sequencer.

## Interface
- CNT_W, 8, width of the HIGH_W, LOW_W and NUM fields and of the internal counters (max value 2^CNT_W-1).

- CLK  input  1  clock; all logic on the rising edge. The block has one clock.
- RST  input  1  reset, synchronous and active-high.
- START  input  1  start request; sampled only in IDLE.
- STOP  input  1  abort request; sampled in every state.
- HIGH_W  input  CNT_W  high-phase length in cycles; captured at accepted START.
- LOW_W  input  CNT_W  low-phase length in cycles; captured at accepted START.
- NUM  input  CNT_W  number of pulses in the burst; captured at accepted START.
- OUT  output  1  registered pulse output.
- BUSY  output  1  registered; high while a burst is in progress.
- DONE  output  1  registered; single-cycle completion strobe.

## Operation
- States: IDLE, HIGH, LOW.
- Reset: state IDLE, OUT=0, BUSY=0, DONE=0, all counters 0. RST overrides every other input.
- Start acceptance in IDLE:
  - START=1, STOP=0, NUM!=0: capture HIGH_W, LOW_W and NUM, then go to HIGH.
  - A zero width is treated as 1. Effective H=max(HIGH_W,1), L=max(LOW_W,1).
  - START=1, NUM=0: no pulses; DONE=1 for one cycle, state stays IDLE.
- HIGH: OUT=1 for H cycles, then go to LOW.
- LOW: OUT=0 for L cycles.
  - If pulses remain, go back to HIGH.
  - After the final low phase, go to IDLE with DONE=1 for one cycle.
- BUSY=1 exactly when the state is HIGH or LOW.
- START while BUSY is ignored. It is not queued.
- Input changes on HIGH_W, LOW_W or NUM mid-burst have no effect, because the values are captured at start.
- STOP=1 in HIGH or LOW: next cycle OUT=0, BUSY=0, state IDLE, DONE stays 0 (an aborted burst never signals DONE).
- STOP=1 in IDLE: any START in the same cycle is dropped.
- A START asserted in the DONE cycle is accepted, because the state is IDLE.
  - The previous burst's final low phase then guarantees at least L low cycles between bursts.
- Counters:
  - Phase counter counts down from H-1 or L-1.
  - Pulse counter counts down from NUM-1.
  - Counters never wrap: the count of 2^CNT_W-1 is reachable and behaves like any other value.

## Timing
- START sampled high at the edge ending cycle 0 → OUT=1 and BUSY=1 in cycle 1.
- Pulse k (k=0..N-1) is high in cycles 1+k(H+L) .. k(H+L)+H.
- The following low phase occupies the next L cycles.
- BUSY is high for exactly N·(H+L) cycles: cycles 1 .. N(H+L).
- DONE=1 in cycle N(H+L)+1, with BUSY=0 and OUT=0 in that cycle.
- NUM=0 start: DONE=1 in cycle 1; OUT and BUSY stay 0.
- STOP sampled in cycle c (busy) → OUT=0 and BUSY=0 from cycle c+1.
- RST sampled in cycle c → all outputs 0 from cycle c+1, regardless of state.
- Every output is a flop: no combinational path from any input to any output.

## Test plan
- Reset: assert RST for 2 cycles mid-burst (H=4, L=4, N=3) → OUT/BUSY/DONE = 0 from the next cycle; a later START restarts cleanly from pulse 0.
- Basic burst: H=3, L=2, N=2, START at cycle 0 → OUT high in cycles 1-3 and 6-8, low in 4-5 and 9-10; BUSY in 1-10; DONE only in 11. Feed OUT into the edge detector and count exactly 2 rising edges.
- Zero fields: HIGH_W=0, LOW_W=0, N=3 → OUT alternates 1,0 over cycles 1-6; DONE at 7. A separate start with NUM=0 → DONE at 1 and no OUT activity.
- Ignored start and late field changes: during a burst (H=2, L=2, N=4), pulse START and change HIGH_W to 9 → the burst shape is unchanged and exactly 1 DONE occurs at cycle 17.
- Abort and collision:
  - STOP in cycle 5 of H=4, L=4, N=2 → OUT=0 and BUSY=0 from cycle 6; DONE never asserts.
  - START and STOP together in IDLE → nothing starts.
- Back-to-back and maximum values:
  - START held high continuously with H=1, L=1, N=1 → a new burst starts in each DONE cycle; the period is 3 cycles.
  - H=255, L=255, N=255 (CNT_W=8) → BUSY lasts 130050 cycles, with no counter wrap.

Source files
------------

// File: rtl/pulse_burst_gen_if.sv
// Control/status bundle between a sequencer and pulse_burst_gen.
interface pulse_burst_gen_if #(
    parameter int unsigned CNT_W = 8
);
    logic             START;
    logic             STOP;
    logic [CNT_W-1:0] HIGH_W;
    logic [CNT_W-1:0] LOW_W;
    logic [CNT_W-1:0] NUM;
    logic             OUT;
    logic             BUSY;
    logic             DONE;

    // Sequencer side: issues commands, observes pulse output and status
    modport master (
        output START, STOP, HIGH_W, LOW_W, NUM,
        input  OUT, BUSY, DONE
    );

    // Generator side
    modport slave (
        input  START, STOP, HIGH_W, LOW_W, NUM,
        output OUT, BUSY, DONE
    );
endinterface

// File: rtl/pulse_burst_gen.sv
// Programmable pulse-burst generator: NUM pulses of H cycles high then L cycles
// low, followed by a one-cycle DONE strobe. Every output is a flop.
module pulse_burst_gen #(
    parameter int unsigned CNT_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    pulse_burst_gen_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] pulse_q, pulse_d;
    logic [CNT_W-1:0] h_q,     h_d;
    logic [CNT_W-1:0] l_q,     l_d;
    logic             out_q,   out_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    // Zero widths are promoted to one cycle at capture time
    logic [CNT_W-1:0] h_eff_c;
    logic [CNT_W-1:0] l_eff_c;

    // Effective phase lengths from the live inputs
    always_comb begin
        h_eff_c = (bus.HIGH_W == '0) ? CNT_W'(1) : bus.HIGH_W;
        l_eff_c = (bus.LOW_W  == '0) ? CNT_W'(1) : bus.LOW_W;
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        pulse_d = pulse_q;
        h_d     = h_q;
        l_d     = l_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.START && !bus.STOP) begin
                    if (bus.NUM == '0) begin
                        done_d = 1'b1;
                    end else begin
                        h_d     = h_eff_c;
                        l_d     = l_eff_c;
                        pulse_d = bus.NUM - CNT_W'(1);
                        phase_d = h_eff_c - CNT_W'(1);
                        state_d = ST_HIGH;
                        out_d   = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_HIGH: begin
                if (bus.STOP) begin
                    state_d = ST_IDLE;
                    out_d   = 1'b0;
                    busy_d  = 1'b0;
                end else if (phase_q == '0) begin
                    state_d = ST_LOW;
                    phase_d = l_q - CNT_W'(1);
                    out_d   = 1'b0;
                end else begin
                    phase_d = phase_q - CNT_W'(1);
                end
            end
            ST_LOW: begin
                if (bus.STOP) begin
                    state_d = ST_IDLE;
                    out_d   = 1'b0;
                    busy_d  = 1'b0;
                end else if (phase_q == '0) begin
                    if (pulse_q == '0) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        pulse_d = pulse_q - CNT_W'(1);
                        phase_d = h_q - CNT_W'(1);
                        state_d = ST_HIGH;
                        out_d   = 1'b1;
                    end
                end else begin
                    phase_d = phase_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                out_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            pulse_q <= '0;
            h_q     <= '0;
            l_q     <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            pulse_q <= pulse_d;
            h_q     <= h_d;
            l_q     <= l_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.OUT  = out_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
endmodule

// File: tb/tb_pulse_burst_gen.sv
// Scoreboard bench for pulse_burst_gen: the driver predicts each next-cycle
// output triple from a timeline model of the burst; the monitor compares.
module tb_pulse_burst_gen;
    localparam int unsigned CNT_W = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    pulse_burst_gen_if #(.CNT_W(CNT_W)) bus();

    pulse_burst_gen #(.CNT_W(CNT_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    // expected {OUT, BUSY, DONE} for successive cycles
    logic [2:0] sb[$];

    int vectors    = 0;
    int miscompares = 0;

    // timeline model: a burst is (start reference, H, L, N); t is the cycle
    // index within the burst, 1 .. N*(H+L), and N*(H+L)+1 is the DONE cycle
    bit m_active = 1'b0;
    int m_t = 0;
    int m_h = 0;
    int m_l = 0;
    int m_n = 0;

    // receiving end: two-flop synchronizer plus rising-edge detector
    logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
    int   edge_cnt = 0;
    int   done_cnt = 0;

    always @(posedge CLK) begin
        s1 <= bus.OUT;
        s2 <= s1;
        s3 <= s2;
        if (s2 && !s3) edge_cnt <= edge_cnt + 1;
        if (bus.DONE === 1'b1) done_cnt <= done_cnt + 1;
    end

    // monitor: one expected triple per cycle, sampled after the edge
    int cyc = 0;
    always @(posedge CLK) begin
        logic [2:0] e;
        logic [2:0] a;
        #1;
        cyc++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a = {bus.OUT, bus.BUSY, bus.DONE};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL cycle_check t=%0t got OUT/BUSY/DONE=%b expected %b", $time, a, e);
            end
        end
    end

    task automatic check_eq(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // drive one cycle of inputs and predict the outputs of the following cycle
    task automatic step(input bit rst, input bit start, input bit stop,
                        input int hw, input int lw, input int num);
        logic [2:0] e;
        @(negedge CLK);
        RST        = rst;
        bus.START  = start;
        bus.STOP   = stop;
        bus.HIGH_W = 8'(hw);
        bus.LOW_W  = 8'(lw);
        bus.NUM    = 8'(num);
        e = 3'b000;
        if (rst) begin
            m_active = 1'b0;
        end else if (m_active) begin
            if (stop) begin
                m_active = 1'b0;
            end else begin
                m_t++;
                if (m_t > m_n * (m_h + m_l)) begin
                    m_active = 1'b0;
                    e[0] = 1'b1;
                end else begin
                    e[1] = 1'b1;
                    e[2] = (((m_t - 1) % (m_h + m_l)) < m_h);
                end
            end
        end else if (start && !stop) begin
            if (num == 0) begin
                e[0] = 1'b1;
            end else begin
                m_active = 1'b1;
                m_t = 1;
                m_h = (hw == 0) ? 1 : hw;
                m_l = (lw == 0) ? 1 : lw;
                m_n = num;
                e = 3'b110;
            end
        end
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    initial begin
        int e0;
        int d0;
        bus.START = 1'b0; bus.STOP = 1'b0;
        bus.HIGH_W = '0; bus.LOW_W = '0; bus.NUM = '0;

        // reset
        step(1'b1, 1'b0, 1'b0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0, 0);
        idle(2);

        // basic burst H=3 L=2 N=2, two edges at the receiver
        e0 = edge_cnt; d0 = done_cnt;
        step(1'b0, 1'b1, 1'b0, 3, 2, 2);
        idle(14);
        check_eq("basic_edges", edge_cnt - e0, 2);
        check_eq("basic_done", done_cnt - d0, 1);

        // zero widths, then a NUM=0 start
        e0 = edge_cnt; d0 = done_cnt;
        step(1'b0, 1'b1, 1'b0, 0, 0, 3);
        idle(10);
        check_eq("zero_w_edges", edge_cnt - e0, 3);
        e0 = edge_cnt;
        step(1'b0, 1'b1, 1'b0, 5, 5, 0);
        idle(5);
        check_eq("num0_edges", edge_cnt - e0, 0);
        check_eq("zero_done", done_cnt - d0, 2);

        // ignored START and late field change mid-burst
        d0 = done_cnt;
        step(1'b0, 1'b1, 1'b0, 2, 2, 4);
        for (int i = 1; i <= 16; i++) step(1'b0, (i % 3) == 0, 1'b0, 9, 2, 4);
        idle(4);
        check_eq("ignored_start_done", done_cnt - d0, 1);

        // abort in cycle 5
        d0 = done_cnt;
        step(1'b0, 1'b1, 1'b0, 4, 4, 2);
        idle(4);
        step(1'b0, 1'b0, 1'b1, 4, 4, 2);
        idle(20);
        check_eq("abort_no_done", done_cnt - d0, 0);

        // START with STOP in IDLE
        step(1'b0, 1'b1, 1'b1, 3, 3, 3);
        idle(3);

        // reset mid-burst, then clean restart
        step(1'b0, 1'b1, 1'b0, 4, 4, 3);
        idle(5);
        step(1'b1, 1'b1, 1'b0, 4, 4, 3);
        step(1'b1, 1'b0, 1'b0, 4, 4, 3);
        idle(2);
        e0 = edge_cnt;
        step(1'b0, 1'b1, 1'b0, 4, 4, 3);
        idle(28);
        check_eq("restart_edges", edge_cnt - e0, 3);

        // START held high, H=L=N=1: new burst every DONE cycle
        d0 = done_cnt;
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, 1, 1, 1);
        idle(4);
        check_eq("b2b_done", done_cnt - d0, 4);

        // maximum widths and maximum pulse count
        d0 = done_cnt;
        step(1'b0, 1'b1, 1'b0, 255, 255, 2);
        idle(1022);
        e0 = edge_cnt;
        step(1'b0, 1'b1, 1'b0, 1, 1, 255);
        idle(514);
        check_eq("max_num_edges", edge_cnt - e0, 255);
        check_eq("max_done", done_cnt - d0, 2);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 29) == 0),
                 int'($urandom_range(0, 5)),
                 int'($urandom_range(0, 5)),
                 int'($urandom_range(0, 4)));
        end
        idle(40);

        @(posedge CLK);
        #2;
        check_eq("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // global time bound
    initial begin
        #2000000;
        $display("FAIL timeout got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
